// File: rtl/tpu_pkg.sv
// Shared definitions for the loss sequencer: FSM states, batch limits, Q8.8 format and the 2/N table.
`default_nettype none

package tpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  localparam int MAX_BATCH = 16;
  localparam int BATCH_W   = 5;
  localparam int ADDR_W    = 4;

  localparam int Q_WIDTH = 16;
  localparam int Q_FRAC  = 8;
  localparam int Q_INT   = Q_WIDTH - Q_FRAC;

  // round(2/N * 2^Q_FRAC) = round(512/N), halves rounded up; 0 for out-of-range N
  function automatic logic [Q_WIDTH-1:0] inv_batch_times_two(input logic [BATCH_W-1:0] n);
    logic [Q_WIDTH-1:0] v;
    v = '0;
    case (n)
      5'd1:    v = 16'd512;
      5'd2:    v = 16'd256;
      5'd3:    v = 16'd171;
      5'd4:    v = 16'd128;
      5'd5:    v = 16'd102;
      5'd6:    v = 16'd85;
      5'd7:    v = 16'd73;
      5'd8:    v = 16'd64;
      5'd9:    v = 16'd57;
      5'd10:   v = 16'd51;
      5'd11:   v = 16'd47;
      5'd12:   v = 16'd43;
      5'd13:   v = 16'd39;
      5'd14:   v = 16'd37;
      5'd15:   v = 16'd34;
      5'd16:   v = 16'd32;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/loss_seq_column.sv
// One column of the loss sequencer: row counter, target read issue, operand register, gradient counter.
`default_nettype none

module loss_seq_column
  import tpu_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      run,
  input  logic                      count_grad,
  input  logic [BATCH_W-1:0]        n,
  input  logic signed [Q_WIDTH-1:0] h_in,
  input  logic                      h_valid_in,
  input  logic signed [Q_WIDTH-1:0] y_rd_data_in,
  input  logic                      grad_valid_in,
  output logic                      rd_en_out,
  output logic [ADDR_W-1:0]         rd_addr_out,
  output logic signed [Q_WIDTH-1:0] H_out,
  output logic signed [Q_WIDTH-1:0] Y_out,
  output logic                      valid_out,
  output logic                      rows_done_out,
  output logic                      grads_done_out,
  output logic                      overflow_out
);

  logic [BATCH_W-1:0]        row_cnt;
  logic [BATCH_W-1:0]        grad_cnt;
  logic signed [Q_WIDTH-1:0] h_reg;
  logic                      pend;
  logic                      accept;

  assign accept       = run && h_valid_in && (row_cnt < n);
  assign overflow_out = h_valid_in && !accept;

  // row_cnt < n <= MAX_BATCH, so the low bits are always a valid row address
  assign rd_en_out   = accept;
  assign rd_addr_out = accept ? row_cnt[ADDR_W-1:0] : '0;

  // Target data arrives one cycle after the read, aligned with the registered H
  assign valid_out = pend;
  assign H_out     = pend ? h_reg : '0;
  assign Y_out     = pend ? y_rd_data_in : '0;

  assign rows_done_out  = (row_cnt == n);
  assign grads_done_out = (grad_cnt == n);

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt  <= '0;
      grad_cnt <= '0;
      h_reg    <= '0;
      pend     <= 1'b0;
    end else begin
      pend <= accept;
      if (accept) begin
        h_reg <= h_in;
      end
      if (clear) begin
        row_cnt  <= '0;
        grad_cnt <= '0;
      end else begin
        if (accept) begin
          row_cnt <= row_cnt + 5'd1;
        end
        if (count_grad && grad_valid_in && (grad_cnt < n)) begin
          grad_cnt <= grad_cnt + 5'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/loss_sequencer.sv
// Loss pass sequencer: IDLE->RUN->DRAIN->DONE over two independent columns.
// Optional LOSS_SEQ_CYCLE_COUNT_EN adds a saturating busy-cycle counter output.
`default_nettype none

module loss_sequencer
  import tpu_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_in,
  input  logic [BATCH_W-1:0]        batch_size_in,
  input  logic signed [Q_WIDTH-1:0] h_1_in,
  input  logic signed [Q_WIDTH-1:0] h_2_in,
  input  logic                      h_valid_1_in,
  input  logic                      h_valid_2_in,
  output logic                      y_1_rd_en_out,
  output logic                      y_2_rd_en_out,
  output logic [ADDR_W-1:0]         y_1_rd_addr_out,
  output logic [ADDR_W-1:0]         y_2_rd_addr_out,
  input  logic signed [Q_WIDTH-1:0] y_1_rd_data_in,
  input  logic signed [Q_WIDTH-1:0] y_2_rd_data_in,
  output logic signed [Q_WIDTH-1:0] H_1_out,
  output logic signed [Q_WIDTH-1:0] Y_1_out,
  output logic signed [Q_WIDTH-1:0] H_2_out,
  output logic signed [Q_WIDTH-1:0] Y_2_out,
  output logic                      valid_1_out,
  output logic                      valid_2_out,
  output logic signed [Q_WIDTH-1:0] inv_batch_size_times_two_out,
  input  logic                      gradient_valid_1_in,
  input  logic                      gradient_valid_2_in,
  output logic                      busy_out,
  output logic                      done_out,
`ifdef LOSS_SEQ_CYCLE_COUNT_EN
  output logic [15:0]               cycle_count_out,
`endif
  output logic                      error_out
);

  seq_state_t         state_q, state_d;
  logic [BATCH_W-1:0] n_q;
  logic [Q_WIDTH-1:0] inv_q;
  logic               err_q;

  logic batch_legal, start_ok, start_bad;
  logic run, count_grad;
  logic rows_done_1, rows_done_2, grads_done_1, grads_done_2;
  logic overflow_1, overflow_2;

  assign batch_legal = (batch_size_in != '0) && (batch_size_in <= BATCH_W'(MAX_BATCH));
  assign start_ok    = (state_q == ST_IDLE) && start_in && batch_legal;
  assign start_bad   = (state_q == ST_IDLE) && start_in && !batch_legal;

  assign run        = (state_q == ST_RUN);
  // Gradients may return while rows are still streaming, so count in RUN as well
  assign count_grad = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_RUN;
      ST_RUN:   if (rows_done_1 && rows_done_2) state_d = ST_DRAIN;
      ST_DRAIN: if (grads_done_1 && grads_done_2) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      inv_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        n_q   <= batch_size_in;
        inv_q <= inv_batch_times_two(batch_size_in);
      end
      if (start_bad || overflow_1 || overflow_2) begin
        err_q <= 1'b1;
      end
    end
  end

  assign busy_out                     = (state_q != ST_IDLE);
  assign done_out                     = (state_q == ST_DONE);
  assign error_out                    = err_q;
  assign inv_batch_size_times_two_out = inv_q;

`ifdef LOSS_SEQ_CYCLE_COUNT_EN
  logic [15:0] cyc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
    end else if (start_ok) begin
      cyc_q <= '0;
    end else if (busy_out && (cyc_q != 16'hFFFF)) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end

  assign cycle_count_out = cyc_q;
`endif

  loss_seq_column u_col_1 (
    .clk            (clk),
    .rst            (rst),
    .clear          (start_ok),
    .run            (run),
    .count_grad     (count_grad),
    .n              (n_q),
    .h_in           (h_1_in),
    .h_valid_in     (h_valid_1_in),
    .y_rd_data_in   (y_1_rd_data_in),
    .grad_valid_in  (gradient_valid_1_in),
    .rd_en_out      (y_1_rd_en_out),
    .rd_addr_out    (y_1_rd_addr_out),
    .H_out          (H_1_out),
    .Y_out          (Y_1_out),
    .valid_out      (valid_1_out),
    .rows_done_out  (rows_done_1),
    .grads_done_out (grads_done_1),
    .overflow_out   (overflow_1)
  );

  loss_seq_column u_col_2 (
    .clk            (clk),
    .rst            (rst),
    .clear          (start_ok),
    .run            (run),
    .count_grad     (count_grad),
    .n              (n_q),
    .h_in           (h_2_in),
    .h_valid_in     (h_valid_2_in),
    .y_rd_data_in   (y_2_rd_data_in),
    .grad_valid_in  (gradient_valid_2_in),
    .rd_en_out      (y_2_rd_en_out),
    .rd_addr_out    (y_2_rd_addr_out),
    .H_out          (H_2_out),
    .Y_out          (Y_2_out),
    .valid_out      (valid_2_out),
    .rows_done_out  (rows_done_2),
    .grads_done_out (grads_done_2),
    .overflow_out   (overflow_2)
  );

endmodule

`default_nettype wire

// File: doc/loss_sequencer.md
LOSS_SEQUENCER -- requirements
Module: loss_sequencer

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 SHALL have the following ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start_in  in  1  one-cycle pulse that starts a loss pass
- batch_size_in  in  5  rows per pass, legal range 1..16
- h_1_in, h_2_in  in  16 signed  systolic column outputs, Q8.8
- h_valid_1_in, h_valid_2_in  in  1  column output valid
- y_1_rd_en_out, y_2_rd_en_out  out  1  target-buffer read enables
- y_1_rd_addr_out, y_2_rd_addr_out  out  4  target-buffer row addresses
- y_1_rd_data_in, y_2_rd_data_in  in  16 signed  target data, 1-cycle read latency
- H_1_out, Y_1_out, H_2_out, Y_2_out  out  16 signed  operands to the loss datapath
- valid_1_out, valid_2_out  out  1  operand valid
- inv_batch_size_times_two_out  out  16 signed  2/N in Q8.8
- gradient_valid_1_in, gradient_valid_2_in  in  1  loss datapath result valid
- busy_out  out  1  pass in progress
- done_out  out  1  one-cycle pass-complete pulse
- error_out  out  1  sticky error flag

Function
REQ-003 SHALL implement the FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
REQ-004 SHALL, in IDLE on start_in with a legal batch_size_in, latch N, load inv_batch_size_times_two_out with round(512/N), clear all counters and enter RUN.
REQ-005 SHALL treat a batch_size_in of 0 or greater than 16 at start_in as illegal: set error_out and remain in IDLE.
REQ-006 SHALL, per column k in RUN, on h_valid_k_in with row_cnt_k < N: assert y_k_rd_en_out with y_k_rd_addr_out = row_cnt_k, register h_k_in, and increment row_cnt_k.
REQ-007 SHALL, one cycle after REQ-006, drive H_k_out = registered H, Y_k_out = y_k_rd_data_in, and valid_k_out = 1, giving a fixed latency of 1 cycle from h_valid to valid.
REQ-008 SHALL keep the two columns independent, so that a 1-cycle column skew is tolerated without stalling.
REQ-009 SHALL ignore an h_valid_k_in when row_cnt_k = N or when the FSM is not in RUN, and SHALL set error_out in that case.
REQ-010 SHALL move from RUN to DRAIN when both row_cnt equal N.
REQ-011 SHALL count gradient_valid_k_in per column; DRAIN SHALL move to DONE when both gradient counts equal N.
REQ-012 SHALL raise done_out for exactly the DONE cycle.
REQ-013 SHALL assert busy_out in RUN, DRAIN and DONE.
REQ-014 SHALL ignore start_in while busy_out is high.
REQ-015 SHALL hold inv_batch_size_times_two_out stable from RUN entry until the next start_in.
REQ-016 SHALL keep error_out sticky until rst; error SHALL NOT abort a pass in progress.

Reset
REQ-017 SHALL, on rst, return the FSM to IDLE and drive every output to 0, including inv_batch_size_times_two_out and error_out.
REQ-018 SHALL abandon a pass when rst arrives mid-pass: no done_out is produced, and valid outputs are 0 on the next cycle.

Configuration
REQ-019 SHALL, with LOSS_SEQ_CYCLE_COUNT_EN defined, add output cycle_count_out (16 bits): it clears on RUN entry, increments each busy cycle, saturates at 0xFFFF, and holds after DONE.
REQ-020 SHALL, without LOSS_SEQ_CYCLE_COUNT_EN, omit the port and its counter entirely.

Structure
REQ-021 SHALL place the FSM state enum, MAX_BATCH = 16, the Q8.8 format constants and the 2/N lookup table (entries 1..16) in the shared package tpu_pkg.
REQ-022 SHALL instantiate one sub-module, loss_seq_column, twice (row counter, read issue, operand register, gradient counter); the FSM stays in the top level.

Verification
REQ-023 SHALL cover these directed scenarios:
- N=4, column 2 lagging 1 cycle, gradients returned 2 cycles after valid -> each valid_k_out 1 cycle after h_valid; addresses 0..3; done_out exactly once; inv_batch_size_times_two_out = 128.
- N=3 -> inv_batch_size_times_two_out = 171; N=1 -> 512; N=16 -> 32.
- start_in with batch_size_in = 0, then 17 -> error_out = 1, busy_out = 0, no read enables.
- N=2 with a third h_valid_1_in -> third value is not forwarded, error_out = 1, pass still completes with done_out.
- rst asserted in DRAIN -> next cycle all outputs 0 and FSM in IDLE; a new start with N=2 completes normally.
- start_in pulsed during RUN -> ignored, N unchanged; with LOSS_SEQ_CYCLE_COUNT_EN defined, cycle_count_out equals the number of busy cycles.
